cmp_result_tracker: RTL
=======================

Name: cmp_result_tracker

Overview:
Sits directly downstream of the 4-bit magnitude comparator and consumes its eq/gt/lt flags as a valid/ready sample stream. It tallies results over a window of WINDOW samples and counts illegal flag encodings. At window close, or on flush, it presents a registered report behind a valid/ready handshake. It also flags runs of identical results.

Parameters:
WINDOW, 8, samples per report window (>=1)
CNT_W, 4, width of all counters; must satisfy 2^CNT_W-1 >= WINDOW
STREAK_LEN, 3, consecutive same-class samples that raise streak_alarm (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  sample present
in_ready  out  1  tracker accepts sample
eq  in  1  comparator equal flag
gt  in  1  comparator greater flag
lt  in  1  comparator less flag
flush  in  1  close the window early
out_valid  out  1  report present
out_ready  in  1  consumer takes report
out_eq_cnt  out  CNT_W  eq samples in window
out_gt_cnt  out  CNT_W  gt samples in window
out_lt_cnt  out  CNT_W  lt samples in window
out_err_cnt  out  CNT_W  illegal-encoding samples in window
out_total  out  CNT_W  accepted samples in window
streak_alarm  out  1  run of STREAK_LEN identical classes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state ACCUM; all counters, all out_* signals and streak_alarm are 0; in_ready is forced to 0 while rst is high.
- Accept: a sample is accepted when in_valid && in_ready. in_ready = (state==ACCUM) && !rst.
- Classify: exactly one of {eq,gt,lt} high gives EQ/GT/LT, and the matching counter increments. Any other pattern (000, 110, 111, ...) gives ERR and err_cnt increments. total increments for every accepted sample.
- Latency: a sample accepted in cycle N is reflected in the internal counters at N+1.
- FSM, ACCUM -> REPORT: when the accepted sample makes total==WINDOW, or flush=1 while (total>0 or a sample is accepted that cycle).
  - The out_* registers load the counts including that cycle's sample.
  - out_valid=1 from the next cycle.
- flush=1 with total==0 and no accept: ignored. flush in REPORT: ignored.
- FSM, REPORT: out_* are held stable and in_ready=0.
  - On out_valid && out_ready: return to ACCUM, clear all window counters, and drop out_valid next cycle.
  - out_* retain their last values after out_valid drops.
- Throughput: at least one bubble per window. Best case is WINDOW samples per WINDOW+1 cycles.
- Saturation: counters never exceed WINDOW by construction. No wrap is possible.
- Reset mid-REPORT: the report is discarded, out_valid=0 on the next edge, and counters clear.

Optional Feature:
Macro CMP_RESULT_TRACKER_STREAK_EN.
- Defined:
  - A streak counter tracks the class of the last accepted sample.
  - Same class increments it, saturating at STREAK_LEN. A different valid class resets it to 1. ERR resets it to 0 and last class to NONE.
  - streak_alarm is registered and high while streak==STREAK_LEN (cycle after the STREAK_LEN-th consecutive sample).
  - Streaks span window boundaries; only reset or a class change clears them.
- Undefined: no streak logic is synthesised and streak_alarm is tied to 0.

Decomposition:
- Package cmp_tracker_pkg:
  - typedef enum cls_e {CLS_NONE, CLS_EQ, CLS_GT, CLS_LT, CLS_ERR}
  - typedef enum state_e {ST_ACCUM, ST_REPORT}
  - classify function for {eq,gt,lt} -> cls_e
- Sub-module cmp_class_decode: combinational one-hot check producing cls_e. It is shared with future comparator-side monitors.

Test Plan:
1. Reset, then 8 samples eq=1 on back-to-back cycles, out_ready=1 -> out_valid 1 cycle after the 8th sample; eq=8, gt=lt=err=0, total=8; with the macro defined, streak_alarm rises the cycle after the 3rd sample.
2. Sequence gt,lt,eq,gt,lt,eq,gt,gt -> eq=2, gt=4, lt=2, err=0, total=8; streak_alarm stays 0 (max run 2).
3. Encodings 000 and 110 among 8 samples, remainder eq -> err=2, eq=6; streak resets to 0 after each ERR.
4. Full window with out_ready held 0 for 5 cycles -> out_valid and out_* stable, in_ready=0, in_valid ignored; after the handshake the next window's counts start from 0.
5. Three gt samples then flush=1 -> report gt=3, total=3. flush with total=0 -> no out_valid.
6. rst=1 for one cycle during REPORT -> out_valid=0, counters 0 next cycle; in_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/cmp_tracker_pkg.sv
// Shared types and sample classification for the comparator result tracker.
package cmp_tracker_pkg;

   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_EQ,
      CLS_GT,
      CLS_LT,
      CLS_ERR
   } cls_e;

   typedef enum logic {
      ST_ACCUM,
      ST_REPORT
   } state_e;

   // Exactly one flag high is a legal comparator result; anything else is ERR.
   function automatic cls_e classify(input logic eq, input logic gt, input logic lt);
      cls_e c;
      case ({eq, gt, lt})
         3'b100:  c = CLS_EQ;
         3'b010:  c = CLS_GT;
         3'b001:  c = CLS_LT;
         default: c = CLS_ERR;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cmp_class_decode.sv
// Combinational one-hot check of comparator flags; reusable by other
// comparator-side monitors.
module cmp_class_decode
   import cmp_tracker_pkg::*;
(
   input  logic eq,
   input  logic gt,
   input  logic lt,
   output cls_e cls
);

   always_comb cls = classify(eq, gt, lt);

endmodule

// File: rtl/cmp_result_tracker.sv
// Windowed tally of comparator results with a registered valid/ready report.
// Optional streak detector enabled by defining CMP_RESULT_TRACKER_STREAK_EN.
module cmp_result_tracker
   import cmp_tracker_pkg::*;
#(
   parameter int WINDOW     = 8,
   parameter int CNT_W      = 4,
   parameter int STREAK_LEN = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             eq,
   input  logic             gt,
   input  logic             lt,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_eq_cnt,
   output logic [CNT_W-1:0] out_gt_cnt,
   output logic [CNT_W-1:0] out_lt_cnt,
   output logic [CNT_W-1:0] out_err_cnt,
   output logic [CNT_W-1:0] out_total,
   output logic             streak_alarm
);

   localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

   state_e           state;
   cls_e             cls;
   logic             accept;
   logic             close_win;
   logic [CNT_W-1:0] eq_cnt, gt_cnt, lt_cnt, err_cnt, total;
   logic [CNT_W-1:0] eq_nxt, gt_nxt, lt_nxt, err_nxt, total_nxt;

   cmp_class_decode u_decode (
      .eq  (eq),
      .gt  (gt),
      .lt  (lt),
      .cls (cls)
   );

   always_comb begin
      in_ready  = (state == ST_ACCUM) && !rst;
      accept    = in_valid && in_ready;
      eq_nxt    = eq_cnt  + CNT_W'(accept && (cls == CLS_EQ));
      gt_nxt    = gt_cnt  + CNT_W'(accept && (cls == CLS_GT));
      lt_nxt    = lt_cnt  + CNT_W'(accept && (cls == CLS_LT));
      err_nxt   = err_cnt + CNT_W'(accept && (cls == CLS_ERR));
      total_nxt = total   + CNT_W'(accept);
      // An idle flush on an empty window is dropped rather than reporting zeros.
      close_win = (accept && (total_nxt == WIN)) ||
                  (flush && ((total != '0) || accept));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_ACCUM;
         eq_cnt      <= '0;
         gt_cnt      <= '0;
         lt_cnt      <= '0;
         err_cnt     <= '0;
         total       <= '0;
         out_valid   <= 1'b0;
         out_eq_cnt  <= '0;
         out_gt_cnt  <= '0;
         out_lt_cnt  <= '0;
         out_err_cnt <= '0;
         out_total   <= '0;
      end else begin
         case (state)
            ST_ACCUM: begin
               eq_cnt  <= eq_nxt;
               gt_cnt  <= gt_nxt;
               lt_cnt  <= lt_nxt;
               err_cnt <= err_nxt;
               total   <= total_nxt;
               if (close_win) begin
                  state       <= ST_REPORT;
                  out_valid   <= 1'b1;
                  out_eq_cnt  <= eq_nxt;
                  out_gt_cnt  <= gt_nxt;
                  out_lt_cnt  <= lt_nxt;
                  out_err_cnt <= err_nxt;
                  out_total   <= total_nxt;
               end
            end
            ST_REPORT: begin
               if (out_valid && out_ready) begin
                  state     <= ST_ACCUM;
                  out_valid <= 1'b0;
                  eq_cnt    <= '0;
                  gt_cnt    <= '0;
                  lt_cnt    <= '0;
                  err_cnt   <= '0;
                  total     <= '0;
               end
            end
            default: state <= ST_ACCUM;
         endcase
      end
   end

`ifdef CMP_RESULT_TRACKER_STREAK_EN
   localparam int unsigned    SW         = $clog2(STREAK_LEN + 1);
   localparam logic [SW-1:0]  STREAK_MAX = SW'(STREAK_LEN);

   cls_e          last_cls;
   logic [SW-1:0] streak;
   logic [SW-1:0] streak_nxt;

   // Streak survives window boundaries; only ERR, a class change or reset clear it.
   always_comb begin
      streak_nxt = streak;
      if (accept) begin
         if (cls == CLS_ERR)
            streak_nxt = '0;
         else if (cls == last_cls)
            streak_nxt = (streak == STREAK_MAX) ? streak : streak + 1'b1;
         else
            streak_nxt = SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_cls     <= CLS_NONE;
         streak       <= '0;
         streak_alarm <= 1'b0;
      end else if (accept) begin
         last_cls     <= (cls == CLS_ERR) ? CLS_NONE : cls;
         streak       <= streak_nxt;
         streak_alarm <= (streak_nxt == STREAK_MAX);
      end
   end
`else
   always_comb streak_alarm = 1'b0;
`endif

endmodule
